// File: rtl/inst_encoder_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_if
//   Bundles the request and output handshakes of the instruction encoder.
//   Request side: req_valid/req_ready plus the instruction fields
//   (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm).
//   Output side : out_valid/out_ready plus out_inst, out_addr and out_err.
//   modport slave  : the encoder (consumes requests, produces words)
//   modport master : the loader / IMEM writer side driving it
// ---------------------------------------------------------------------------
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  req_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  out_ready,
    output req_ready,
    output out_valid, out_inst, out_addr, out_err
  );

  modport master (
    output req_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output out_ready,
    input  req_ready,
    input  out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//   Packs RV32I instruction fields and a 32-bit immediate into an instruction
//   word (inverse of the immediate generator) and presents it on a registered
//   valid/ready stage together with an auto-incrementing IMEM byte address.
//   Requests whose immediate cannot be represented in the chosen format (or
//   that use an illegal format) are replaced by NOP_WORD and flagged out_err.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   start       load address counter from base_addr (word aligned), clear err_cnt
//   base_addr   first IMEM byte address
//   bus         request / output handshake bundle (inst_encoder_if.slave)
//   err_cnt     number of errored words accepted downstream, saturating at 255
// ---------------------------------------------------------------------------
module inst_encoder #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  inst_encoder_if.slave     bus,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] accept_addr;
  logic              accept;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic              fits_12;   // imm is a sign-extended 12-bit value
  logic              fits_13;   // imm is a sign-extended 13-bit value
  logic              fits_21;   // imm is a sign-extended 21-bit value

  assign bus.req_ready = !bus.out_valid || bus.out_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  assign base_aligned  = base_addr & ~ADDR_W'(3);
  // A request accepted in the same cycle as start is the first word at base.
  assign accept_addr   = start ? base_aligned : addr_cnt;

  // Sign-extension checks: all bits above the field's sign bit equal it.
  assign fits_12 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign fits_13 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
  assign fits_21 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    case (bus.fmt)
      FMT_R: begin
        enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = !fits_12;
      end
      FMT_S: begin
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        enc_err  = !fits_12;
      end
      FMT_B: begin
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], bus.opcode};
        enc_err  = !fits_13 || bus.imm[0];
      end
      FMT_U: begin
        enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
        enc_err  = |bus.imm[11:0];
      end
      FMT_J: begin
        enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                    bus.rd, bus.opcode};
        enc_err  = !fits_21 || bus.imm[0];
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
    if (enc_err) begin
      enc_word = NOP_WORD;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= '0;
      bus.out_addr  <= '0;
      bus.out_err   <= 1'b0;
      addr_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      // Output stage: load on accept, otherwise drain when consumed, else hold.
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_inst  <= enc_word;
        bus.out_addr  <= accept_addr;
        bus.out_err   <= enc_err;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (accept) begin
        addr_cnt <= accept_addr + ADDR_W'(4);
      end else if (start) begin
        addr_cnt <= base_aligned;
      end

      // Errors are counted when the errored word leaves, not when it enters.
      if (start) begin
        err_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  err_cnt;

  inst_encoder_if #(.ADDR_W(32)) bus ();

  inst_encoder #(.ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    bus.req_valid = 1'b1;
    bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] e, input logic ee);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_inst = e; v.exp_err = ee;
    return v;
  endfunction

  // Reference immediate generator (decode direction).
  function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] f);
    case (f)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'b0};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] f);
    logic [31:0] r;
    r = $urandom;
    case (f)
      3'd1, 3'd2: return {{20{r[11]}}, r[11:0]};
      3'd3:       return {{19{r[12]}}, r[12:1], 1'b0};
      3'd4:       return {r[31:12], 12'b0};
      default:    return {{11{r[20]}}, r[20:1], 1'b0};
    endcase
  endfunction

  vec_t        vecs[20];
  logic [31:0] exp_addr;
  int          exp_errs;

  initial begin
    logic [2:0]  p_fmt;
    logic [6:0]  p_op;
    logic [4:0]  p_rd, p_rs1, p_rs2;
    logic [2:0]  p_f3;
    logic [31:0] p_imm, exp_f, mask;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    bus.req_valid = 1'b0; bus.out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_inst",  64'(bus.out_inst),  64'd0);
    check("rst_out_addr",  64'(bus.out_addr),  64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    check("rst_err_cnt",   64'(err_cnt),       64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;

    // fmt op rd rs1 rs2 f3 f7 imm -> inst err
    vecs[0]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    vecs[1]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    vecs[2]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5,        NOP,           1'b1);
    vecs[3]  = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h0010_006F, 1'b0);
    vecs[4]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[5]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047,     32'h7FF1_0093, 1'b0);
    vecs[6]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048,     NOP,           1'b1);
    vecs[7]  = mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
    vecs[8]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
    vecs[9]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF, NOP,           1'b1);
    vecs[10] = mk(3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        NOP,           1'b1);
    vecs[11] = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        NOP,           1'b1);
    vecs[12] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, NOP,          1'b1);
    vecs[13] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        NOP,           1'b1);
    vecs[14] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
    vecs[15] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, NOP,          1'b1);
    vecs[16] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,     32'h7E20_8FE3, 1'b0);
    vecs[17] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,     NOP,           1'b1);
    vecs[18] = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8001_0093, 1'b0);
    vecs[19] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0);

    exp_addr = 32'h0;
    exp_errs = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      set_req(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
              vecs[i].f3, vecs[i].f7, vecs[i].imm);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_inst", i),  64'(bus.out_inst),  64'(vecs[i].exp_inst));
      check($sformatf("vec%0d_err", i),   64'(bus.out_err),   64'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i),  64'(bus.out_addr),  64'(exp_addr));
      exp_addr += 32'd4;
      if (vecs[i].exp_err) exp_errs++;
      @(posedge clk); #1;
      check($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(exp_errs));
      check($sformatf("vec%0d_drained", i), 64'(bus.out_valid), 64'd0);
    end

    // Round trip at full throughput: decode each word and compare fields.
    @(negedge clk);
    p_fmt = 3'(1 + $urandom_range(0, 4));
    p_op = 7'($urandom); p_rd = 5'($urandom); p_rs1 = 5'($urandom);
    p_rs2 = 5'($urandom); p_f3 = 3'($urandom); p_imm = rand_imm(p_fmt);
    set_req(p_fmt, p_op, p_rd, p_rs1, p_rs2, p_f3, 7'($urandom), p_imm);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      check("rt_imm", 64'(immgen(bus.out_inst, p_fmt)), 64'(p_imm));
      exp_f = {25'd0, p_op};
      mask  = 32'h7F;
      if (p_fmt inside {3'd1, 3'd4, 3'd5}) begin exp_f |= 32'(p_rd) << 7;   mask |= 32'hF80; end
      if (p_fmt inside {3'd1, 3'd2, 3'd3}) begin
        exp_f |= (32'(p_f3) << 12) | (32'(p_rs1) << 15);
        mask  |= 32'h000F_F000;
      end
      if (p_fmt inside {3'd2, 3'd3}) begin exp_f |= 32'(p_rs2) << 20; mask |= 32'h01F0_0000; end
      check("rt_fields", 64'(bus.out_inst & mask), 64'(exp_f));
      check("rt_addr",   64'(bus.out_addr), 64'(exp_addr));
      exp_addr += 32'd4;
      if (i < 9999) begin
        p_fmt = 3'(1 + $urandom_range(0, 4));
        p_op = 7'($urandom); p_rd = 5'($urandom); p_rs1 = 5'($urandom);
        p_rs2 = 5'($urandom); p_f3 = 3'($urandom); p_imm = rand_imm(p_fmt);
        set_req(p_fmt, p_op, p_rd, p_rs1, p_rs2, p_f3, 7'($urandom), p_imm);
      end else begin
        bus.req_valid = 1'b0;
      end
    end

    // Saturation of err_cnt: stream 260 illegal-format requests.
    @(negedge clk);
    set_req(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (260) @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("err_cnt_sat", 64'(err_cnt), 64'd255);

    // Back-pressure with start in the same cycle as the first accept.
    start = 1'b1; base_addr = 32'h0000_0102; bus.out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("bp_a_valid", 64'(bus.out_valid), 64'd1);
    check("bp_a_addr",  64'(bus.out_addr),  64'h100);
    check("bp_a_inst",  64'(bus.out_inst),  64'h0011_0093);
    check("bp_err_clr", 64'(err_cnt),       64'd0);
    check("bp_stalled", 64'(bus.req_ready), 64'd0);
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
    @(negedge clk);
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_addr",  64'(bus.out_addr),  64'h100);
    check("bp_hold_inst",  64'(bus.out_inst),  64'h0011_0093);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_addr", 64'(bus.out_addr), 64'h104);
    check("bp_b_inst", 64'(bus.out_inst), 64'h0021_0093);
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    check("bp_c_addr", 64'(bus.out_addr), 64'h108);
    check("bp_c_inst", 64'(bus.out_inst), 64'h0031_0093);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Address counter wrap.
    start = 1'b1; base_addr = 32'hFFFF_FFFC;
    set_req(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    @(negedge clk);
    start = 1'b0;
    check("wrap_addr_hi", 64'(bus.out_addr), 64'hFFFF_FFFC);
    set_req(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000);
    @(negedge clk);
    check("wrap_addr_0", 64'(bus.out_addr), 64'h0);
    check("wrap_inst",   64'(bus.out_inst), 64'h0000_2137);
    bus.req_valid = 1'b0;
    @(negedge clk);

    // Reset while a word is pending.
    set_req(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.out_ready = 1'b0;
    check("pre_rst_err_cnt", 64'(err_cnt),       64'd1);
    check("pre_rst_valid",   64'(bus.out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid",   64'(bus.out_valid), 64'd0);
    check("mid_rst_inst",    64'(bus.out_inst),  64'd0);
    check("mid_rst_addr",    64'(bus.out_addr),  64'd0);
    check("mid_rst_err",     64'(bus.out_err),   64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt),       64'd0);
    check("mid_rst_ready",   64'(bus.req_ready), 64'd1);
    bus.out_ready = 1'b1;
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("post_rst_addr", 64'(bus.out_addr), 64'd0);
    check("post_rst_inst", 64'(bus.out_inst), 64'h0071_0093);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
